// File: rtl/flexdpe_out_serializer_if.sv
// flexdpe_out_serializer_if: lane-vector input and ready/valid beat output of the serializer
//   i_data_valid / i_data_bus : sparse lane vector from flexdpe
//   o_in_ready                : serializer can capture a vector this cycle
//   o_valid/o_data/o_lane/o_last, i_ready : output beat stream
//   o_count / o_overflow      : snapshot lane count and sticky drop flag
//   master: the serializer side, slave: the surrounding upstream/downstream side
interface flexdpe_out_serializer_if #(
    parameter int OUT_DATA_TYPE = 32,
    parameter int NUM_PES       = 32,
    parameter int LOG2_PES      = 5
);
    logic [NUM_PES-1:0]               i_data_valid;
    logic [NUM_PES*OUT_DATA_TYPE-1:0] i_data_bus;
    logic                             o_in_ready;
    logic                             o_valid;
    logic [OUT_DATA_TYPE-1:0]         o_data;
    logic [LOG2_PES-1:0]              o_lane;
    logic                             o_last;
    logic                             i_ready;
    logic [LOG2_PES:0]                o_count;
    logic                             o_overflow;

    modport master (
        input  i_data_valid, i_data_bus, i_ready,
        output o_in_ready, o_valid, o_data, o_lane, o_last, o_count, o_overflow
    );

    modport slave (
        output i_data_valid, i_data_bus, i_ready,
        input  o_in_ready, o_valid, o_data, o_lane, o_last, o_count, o_overflow
    );
endinterface

// File: rtl/flexdpe_out_serializer.sv
// flexdpe_out_serializer: snapshots a sparse flexdpe lane vector and emits valid lanes one per beat, lowest first
//   clk : system clock
//   rst : asynchronous active-high reset
//   s   : serializer bus (vector in, o_in_ready, beat stream out, o_count, sticky o_overflow)
module flexdpe_out_serializer #(
    parameter int OUT_DATA_TYPE = 32,
    parameter int NUM_PES       = 32,
    parameter int LOG2_PES      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    flexdpe_out_serializer_if.master s
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]                       state_q, state_d;
    logic [NUM_PES-1:0]               mask_q, mask_d;
    logic [NUM_PES*OUT_DATA_TYPE-1:0] data_q, data_d;
    logic [LOG2_PES:0]                count_q, count_d;
    logic                             overflow_q, overflow_d;

    logic [LOG2_PES-1:0] lane;
    logic [LOG2_PES:0]   pop_cnt;
    logic                valid, last, pop, in_ready, any_in;

    // Lowest set mask bit wins: scan downward so the last hit is the smallest index
    always_comb begin
        lane = '0;
        for (int i = NUM_PES - 1; i >= 0; i--)
            if (mask_q[i]) lane = LOG2_PES'(i);
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_PES; i++)
            pop_cnt = pop_cnt + (LOG2_PES + 1)'(s.i_data_valid[i]);
    end

    assign valid    = state_q == DRAIN;
    // Exactly one bit left when clearing the lowest set bit leaves nothing
    assign last     = valid && ((mask_q & (mask_q - NUM_PES'(1))) == '0);
    assign pop      = valid && s.i_ready;
    // Combinational from i_ready so a new vector can land on the final pop without a bubble
    assign in_ready = !valid || (pop && last);
    assign any_in   = |s.i_data_valid;

    always_comb begin
        mask_d     = pop ? mask_q & ~(NUM_PES'(1) << lane) : mask_q;
        state_d    = (pop && last) ? IDLE : state_q;
        data_d     = data_q;
        count_d    = count_q;
        overflow_d = overflow_q || (any_in && !in_ready);
        if (in_ready && any_in) begin
            mask_d  = s.i_data_valid;
            data_d  = s.i_data_bus;
            count_d = pop_cnt;
            state_d = DRAIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign s.o_in_ready = in_ready;
    assign s.o_valid    = valid;
    assign s.o_data     = valid ? data_q[lane*OUT_DATA_TYPE +: OUT_DATA_TYPE] : '0;
    assign s.o_lane     = lane;
    assign s.o_last     = last;
    assign s.o_count    = count_q;
    assign s.o_overflow = overflow_q;
endmodule

// File: tb/tb_flexdpe_out_serializer.sv
// tb_flexdpe_out_serializer: directed self-checking bench for flexdpe_out_serializer
module tb_flexdpe_out_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    flexdpe_out_serializer_if #(.OUT_DATA_TYPE(32), .NUM_PES(32), .LOG2_PES(5)) bus ();

    flexdpe_out_serializer #(.OUT_DATA_TYPE(32), .NUM_PES(32), .LOG2_PES(5)) dut (
        .clk(clk),
        .rst(rst),
        .s  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [31:0] v);
        bus.i_data_bus[k*32 +: 32] = v;
    endtask

    task automatic test_reset;
        bus.i_data_valid = '0;
        bus.i_data_bus   = '0;
        bus.i_ready      = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        tests++; if (bus.o_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %0b want 0", bus.o_valid); end
        tests++; if (bus.o_in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready got %0b want 1", bus.o_in_ready); end
        tests++; if (bus.o_count !== 6'd0) begin failed++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
        tests++; if (bus.o_overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow got %0b want 0", bus.o_overflow); end
        tests++; if (bus.o_data !== 32'h0 || bus.o_lane !== 5'd0 || bus.o_last !== 1'b0) begin
            failed++; $display("FAIL reset_beat got data %h lane %0d last %0b want 0/0/0", bus.o_data, bus.o_lane, bus.o_last);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_lane;
        bus.i_ready = 1'b1;
        bus.i_data_valid = 32'h0000_0001;
        set_lane(0, 32'h4180_0000);
        tick();
        bus.i_data_valid = '0;
        tests++; if (bus.o_valid !== 1'b1 || bus.o_lane !== 5'd0 || bus.o_data !== 32'h4180_0000 || bus.o_last !== 1'b1) begin
            failed++; $display("FAIL single_beat got v%0b lane %0d data %h last %0b want v1 lane 0 data 41800000 last 1", bus.o_valid, bus.o_lane, bus.o_data, bus.o_last);
        end
        tests++; if (bus.o_count !== 6'd1) begin failed++; $display("FAIL single_count got %0d want 1", bus.o_count); end
        tick();
        tests++; if (bus.o_valid !== 1'b0 || bus.o_in_ready !== 1'b1) begin
            failed++; $display("FAIL single_idle got v%0b rdy %0b want v0 rdy 1", bus.o_valid, bus.o_in_ready);
        end
    endtask

    task automatic test_two_lanes;
        bus.i_ready = 1'b1;
        bus.i_data_valid = 32'h0002_0008;
        set_lane(3, 32'h4100_0000);
        set_lane(17, 32'h4140_0000);
        tick();
        bus.i_data_valid = '0;
        tests++; if (bus.o_valid !== 1'b1 || bus.o_lane !== 5'd3 || bus.o_data !== 32'h4100_0000 || bus.o_last !== 1'b0) begin
            failed++; $display("FAIL two_beat0 got v%0b lane %0d data %h last %0b want v1 lane 3 data 41000000 last 0", bus.o_valid, bus.o_lane, bus.o_data, bus.o_last);
        end
        tests++; if (bus.o_count !== 6'd2) begin failed++; $display("FAIL two_count got %0d want 2", bus.o_count); end
        tick();
        tests++; if (bus.o_valid !== 1'b1 || bus.o_lane !== 5'd17 || bus.o_data !== 32'h4140_0000 || bus.o_last !== 1'b1) begin
            failed++; $display("FAIL two_beat1 got v%0b lane %0d data %h last %0b want v1 lane 17 data 41400000 last 1", bus.o_valid, bus.o_lane, bus.o_data, bus.o_last);
        end
        tick();
        tests++; if (bus.o_valid !== 1'b0) begin failed++; $display("FAIL two_idle got v%0b want 0", bus.o_valid); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_data [3];
        exp_data[0] = 32'h3F80_0000;
        exp_data[1] = 32'h4000_0000;
        exp_data[2] = 32'h4040_0000;
        bus.i_ready = 1'b0;
        bus.i_data_valid = 32'h0000_0007;
        for (int k = 0; k < 3; k++) set_lane(k, exp_data[k]);
        tick();
        bus.i_data_valid = '0;
        for (int c = 0; c < 3; c++) begin
            tests++; if (bus.o_valid !== 1'b1 || bus.o_lane !== 5'd0 || bus.o_data !== 32'h3F80_0000 || bus.o_last !== 1'b0 || bus.o_in_ready !== 1'b0) begin
                failed++; $display("FAIL bp_hold%0d got v%0b lane %0d data %h last %0b rdy %0b want v1 lane 0 data 3f800000 last 0 rdy 0", c, bus.o_valid, bus.o_lane, bus.o_data, bus.o_last, bus.o_in_ready);
            end
            if (c < 2) tick();
        end
        bus.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++; if (bus.o_valid !== 1'b1 || bus.o_lane !== 5'(k) || bus.o_data !== exp_data[k] || bus.o_last !== (k == 2)) begin
                failed++; $display("FAIL bp_beat%0d got v%0b lane %0d data %h last %0b want v1 lane %0d data %h last %0b", k, bus.o_valid, bus.o_lane, bus.o_data, bus.o_last, k, exp_data[k], k == 2);
            end
            tick();
        end
        tests++; if (bus.o_valid !== 1'b0) begin failed++; $display("FAIL bp_idle got v%0b want 0", bus.o_valid); end
    endtask

    task automatic test_overflow;
        bus.i_ready = 1'b1;
        bus.i_data_valid = 32'h0000_0003;
        set_lane(0, 32'h0000_000A);
        set_lane(1, 32'h0000_000B);
        set_lane(2, 32'h0000_000C);
        tick();
        bus.i_data_valid = 32'h0000_0004;
        tests++; if (bus.o_lane !== 5'd0 || bus.o_data !== 32'h0000_000A || bus.o_in_ready !== 1'b0) begin
            failed++; $display("FAIL ovf_beat0 got lane %0d data %h rdy %0b want lane 0 data 0000000a rdy 0", bus.o_lane, bus.o_data, bus.o_in_ready);
        end
        tick();
        bus.i_data_valid = '0;
        tests++; if (bus.o_overflow !== 1'b1) begin failed++; $display("FAIL ovf_flag got %0b want 1", bus.o_overflow); end
        tests++; if (bus.o_valid !== 1'b1 || bus.o_lane !== 5'd1 || bus.o_data !== 32'h0000_000B || bus.o_last !== 1'b1) begin
            failed++; $display("FAIL ovf_beat1 got v%0b lane %0d data %h last %0b want v1 lane 1 data 0000000b last 1", bus.o_valid, bus.o_lane, bus.o_data, bus.o_last);
        end
        tick();
        tests++; if (bus.o_valid !== 1'b0) begin failed++; $display("FAIL ovf_dropped got v%0b lane %0d want v0", bus.o_valid, bus.o_lane); end
        tick();
        tests++; if (bus.o_overflow !== 1'b1) begin failed++; $display("FAIL ovf_sticky got %0b want 1", bus.o_overflow); end
    endtask

    task automatic test_back_to_back;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        bus.i_ready = 1'b1;
        bus.i_data_valid = 32'hFFFF_FFFF;
        for (int k = 0; k < 32; k++) set_lane(k, 32'h1000 + k);
        tick();
        bus.i_data_valid = '0;
        for (int k = 0; k < 32; k++) begin
            tests++; if (bus.o_valid !== 1'b1 || bus.o_lane !== 5'(k) || bus.o_data !== 32'h1000 + k || bus.o_last !== (k == 31)) begin
                failed++; $display("FAIL b2b_beat%0d got v%0b lane %0d data %h last %0b want v1 lane %0d data %h last %0b", k, bus.o_valid, bus.o_lane, bus.o_data, bus.o_last, k, 32'h1000 + k, k == 31);
            end
            if (k == 31) begin
                bus.i_data_valid = 32'h0000_0001;
                set_lane(0, 32'h5555_AAAA);
                #1;
                tests++; if (bus.o_in_ready !== 1'b1) begin failed++; $display("FAIL b2b_in_ready got %0b want 1", bus.o_in_ready); end
            end
            tick();
        end
        bus.i_data_valid = '0;
        tests++; if (bus.o_valid !== 1'b1 || bus.o_lane !== 5'd0 || bus.o_data !== 32'h5555_AAAA || bus.o_last !== 1'b1) begin
            failed++; $display("FAIL b2b_next got v%0b lane %0d data %h last %0b want v1 lane 0 data 5555aaaa last 1", bus.o_valid, bus.o_lane, bus.o_data, bus.o_last);
        end
        tests++; if (bus.o_count !== 6'd1 || bus.o_overflow !== 1'b0) begin
            failed++; $display("FAIL b2b_status got count %0d ovf %0b want count 1 ovf 0", bus.o_count, bus.o_overflow);
        end
        tick();
        tests++; if (bus.o_valid !== 1'b0) begin failed++; $display("FAIL b2b_idle got v%0b want 0", bus.o_valid); end
    endtask

    task automatic test_async_reset;
        bus.i_ready = 1'b1;
        bus.i_data_valid = 32'hFFFF_FFFF;
        for (int k = 0; k < 32; k++) set_lane(k, 32'h2000 + k);
        tick();
        bus.i_data_valid = 32'h0000_0001;
        tick();
        bus.i_data_valid = '0;
        repeat (4) tick();
        tests++; if (bus.o_lane !== 5'd5 || bus.o_data !== 32'h2005 || bus.o_overflow !== 1'b1 || bus.o_count !== 6'd32) begin
            failed++; $display("FAIL arst_pre got lane %0d data %h ovf %0b count %0d want lane 5 data 00002005 ovf 1 count 32", bus.o_lane, bus.o_data, bus.o_overflow, bus.o_count);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.o_valid !== 1'b0 || bus.o_count !== 6'd0 || bus.o_overflow !== 1'b0) begin
            failed++; $display("FAIL arst_async got v%0b count %0d ovf %0b want 0/0/0", bus.o_valid, bus.o_count, bus.o_overflow);
        end
        #1;
        rst = 1'b0;
        tick();
        tests++; if (bus.o_in_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            failed++; $display("FAIL arst_after got rdy %0b v%0b want rdy 1 v0", bus.o_in_ready, bus.o_valid);
        end
        tick();
        tests++; if (bus.o_valid !== 1'b0) begin failed++; $display("FAIL arst_residual got v%0b want 0", bus.o_valid); end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_two_lanes();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
